ssd1306_ctrl: RTL and testbench
===============================

# ssd1306_ctrl

SSD1306 display controller that sits directly upstream of the I2C master. After a power-on delay it issues the SSD1306 initialisation command list, one single-byte command transaction at a time. It then streams the full 128x64 framebuffer (1024 bytes) to the panel as one burst data transaction per frame, and repeats the frame indefinitely. It reads pixels from an external framebuffer RAM and drives the master's request, burst and data ports.

## Interface
Parameters:
- CLK_FRE, 50, input clock in MHz; sets the ms tick.
- POR_MS, 100, delay after reset before the first transaction.
- FRAME_GAP_MS, 0, idle gap between frames; 0 = back-to-back.
- SLAVE_ADDR, 8'h78, 8-bit write address of the panel.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, same clock as the I2C master.
- rst  in  1  synchronous, active-high reset.
- slave_addr_ex  out  1  constant 0 (7-bit addressing).
- slave_addr  out  16  {8'h00, SLAVE_ADDR}.
- send_rw  out  1  constant 0 (write only).
- reg_addr  out  8  control byte: 8'h00 = command, 8'h40 = data.
- send_en  out  1  transaction request to master.
- send_busy  in  1  master busy.
- brust_ready  in  1  master finished a burst byte and is in ACK.
- brust_vaild  out  1  another byte follows the current one.
- send_data  out  8  byte for the master.
- fb_addr  out  10  framebuffer read address = page*128 + column.
- fb_data  in  8  framebuffer read data, 1-cycle latency.
- init_done  out  1  high once the init list has been sent; stays high until reset.
- frame_done  out  1  1-cycle pulse after each complete frame.

## Operation
- Synchronise send_busy and brust_ready through 2 flops each. Detect the brust_ready rising edge on the synchronised signal.
- Init list: 31 bytes.
  - AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF
  - then address window 21 00 7F 22 00 07.
- State machine:
  - S_POR: count POR_MS ms, then wait for synchronised send_busy=0 → S_CMD_ISSUE (cmd_idx=0).
  - S_CMD_ISSUE: reg_addr=00, send_data=ROM[cmd_idx], brust_vaild=0, send_en=1. Hold send_en until busy=1, then send_en=0 → S_CMD_WAIT.
  - S_CMD_WAIT: wait busy=0. If cmd_idx=30: set init_done, byte_cnt=0 → S_DATA_LOAD. Else cmd_idx+1 → S_CMD_ISSUE.
  - S_DATA_LOAD: fb_addr=byte_cnt. Next cycle latch fb_data into send_data and set brust_vaild=(byte_cnt!=1023).
    - byte_cnt=0 → S_DATA_ISSUE.
    - otherwise → S_DATA_STREAM.
  - S_DATA_ISSUE: reg_addr=40, send_en=1 until busy=1, then send_en=0 → S_DATA_STREAM.
  - S_DATA_STREAM:
    - On a brust_ready rising edge with byte_cnt<1023: byte_cnt+1 → S_DATA_LOAD.
    - On a brust_ready rising edge with byte_cnt=1023: → S_DATA_END.
  - S_DATA_END: wait busy=0, pulse frame_done → S_GAP.
  - S_GAP: count FRAME_GAP_MS ms, then byte_cnt=0 → S_DATA_LOAD.
- Width rules:
  - byte_cnt is 11 bits; compare against 1023, never wraps.
  - cmd_idx is 5 bits.
  - ms counter counts to CLK_FRE*1000-1.

## Timing
- Reset values:
  - send_en=0, brust_vaild=0, send_data=0, reg_addr=0.
  - slave_addr/slave_addr_ex/send_rw at their constants.
  - fb_addr=0, init_done=0, frame_done=0, state S_POR.
- send_en:
  - Rises 1 cycle after entering an ISSUE state.
  - Falls the cycle after synchronised busy is seen high.
  - Must never be high while busy=0 after a completed transaction.
- Burst update: send_data and brust_vaild update within 4 clk cycles of the brust_ready rising edge. This is well inside the half-SCL window before the master latches the next byte.
- brust_vaild is stable for the whole byte it qualifies.
- Reset mid-transaction: the master may still be busy. S_POR waits for busy=0 after the delay, so the panel is fully re-initialised.
- A brust_ready edge arriving in any state other than S_DATA_STREAM is ignored.

## Structure
- Package ssd1306_pkg holds:
  - state enum;
  - INIT_LEN=31 and the init command constant array;
  - CTRL_CMD=8'h00 and CTRL_DATA=8'h40;
  - FB_BYTES=1024.
- One sub-module, ssd1306_init_rom: combinational 5-bit index → 8-bit command, built from the package array.

## Test plan
- Reset, POR_MS=1, behavioural master model: exactly 31 command transactions, all with reg_addr=00 and brust_vaild=0, bytes in list order AE…07; init_done rises after the 31st busy fall.
- Framebuffer holding fb[i]=i[7:0]: one data transaction with reg_addr=40, 1024 bytes 00,01,…,FF repeating; brust_vaild=0 only on byte 1023; frame_done pulses once.
- FRAME_GAP_MS=1: the next send_en rises no earlier than CLK_FRE*1000 cycles after frame_done; the second frame's data matches the first.
- Assert rst during byte 500 of a burst while the master stays busy for 200 more cycles: all outputs return to reset values; no send_en until busy=0 and POR expires; init restarts at AE.
- Hold send_busy=0 for 50 cycles after send_en: send_en stays high; cmd_idx does not advance.
- Glitch brust_ready during S_CMD_WAIT: no change to byte_cnt or send_data.

Source files
------------

// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 panel controller:
// FSM states, control bytes, framebuffer size and the power-up command list.
package ssd1306_pkg;

  localparam int unsigned INIT_LEN = 31;
  localparam int unsigned FB_BYTES = 1024;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned FB_AW    = 10;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  typedef enum logic [2:0] {
    S_POR,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_DATA_LOAD,
    S_DATA_ISSUE,
    S_DATA_STREAM,
    S_DATA_END,
    S_GAP
  } state_t;

  // Panel bring-up sequence, ending with a full-screen column/page window
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
    8'hAF,
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

endpackage

// File: rtl/ssd1306_init_rom.sv
// Combinational lookup of the init command list; indices past the end read 0.
module ssd1306_init_rom
  import ssd1306_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_cmd_c
);

  always_comb begin
    o_cmd_c = 8'h00;
    if (32'(i_idx) < INIT_LEN) o_cmd_c = INIT_CMDS[i_idx];
  end

endmodule

// File: rtl/ssd1306_ctrl.sv
// SSD1306 controller feeding an I2C master: power-on delay, init command list,
// then endless 1024-byte framebuffer bursts with an optional inter-frame gap.
module ssd1306_ctrl
  import ssd1306_pkg::*;
#(
  parameter int unsigned CLK_FRE      = 50,
  parameter int unsigned POR_MS       = 100,
  parameter int unsigned FRAME_GAP_MS = 0,
  parameter logic [7:0]  SLAVE_ADDR   = 8'h78
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_slave_addr_ex,
  output logic [15:0]      o_slave_addr,
  output logic             o_send_rw,
  output logic [7:0]       o_reg_addr,
  output logic             o_send_en,
  input  logic             i_send_busy,
  input  logic             i_brust_ready,
  output logic             o_brust_vaild,
  output logic [7:0]       o_send_data,
  output logic [FB_AW-1:0] o_fb_addr,
  input  logic [7:0]       i_fb_data,
  output logic             o_init_done,
  output logic             o_frame_done
);

  localparam int unsigned MS_CYC    = CLK_FRE * 1000;
  localparam int unsigned MS_W      = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int unsigned MSN_W     = 16;
  localparam int unsigned LAST_BYTE = FB_BYTES - 1;

  state_t             r_state;
  logic [1:0]         r_busy_sync;
  logic [2:0]         r_rdy_sync;
  logic [MS_W-1:0]    r_ms_cnt;
  logic [MSN_W-1:0]   r_ms_num;
  logic [IDX_W-1:0]   r_cmd_idx;
  logic [CNT_W-1:0]   r_byte_cnt;

  logic               w_busy;
  logic               w_rdy_rise;
  logic               w_timing;
  logic               w_ms_tick;
  logic [MSN_W-1:0]   w_delay_ms;
  logic               w_delay_done;
  logic               w_last_byte;
  logic [FB_AW-1:0]   w_next_addr;
  logic [7:0]         w_rom_cmd;

  assign o_slave_addr_ex = 1'b0;
  assign o_slave_addr    = {8'h00, SLAVE_ADDR};
  assign o_send_rw       = 1'b0;

  assign w_busy       = r_busy_sync[1];
  assign w_rdy_rise   = r_rdy_sync[1] & ~r_rdy_sync[2];
  assign w_timing     = (r_state == S_POR) || (r_state == S_GAP);
  assign w_ms_tick    = (r_ms_cnt == MS_W'(MS_CYC - 1));
  assign w_delay_ms   = (r_state == S_GAP) ? MSN_W'(FRAME_GAP_MS) : MSN_W'(POR_MS);
  assign w_delay_done = (r_ms_num >= w_delay_ms);
  assign w_last_byte  = (r_byte_cnt == CNT_W'(LAST_BYTE));
  // Address of the byte after the current one; wraps to 0 after the last byte
  assign w_next_addr  = FB_AW'(r_byte_cnt + CNT_W'(1));

  ssd1306_init_rom u_init_rom (
    .i_idx   (r_cmd_idx),
    .o_cmd_c (w_rom_cmd)
  );

  // Two-flop synchronisers; the extra ready flop provides the edge reference
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy_sync <= '0;
      r_rdy_sync  <= '0;
    end else begin
      r_busy_sync <= {r_busy_sync[0], i_send_busy};
      r_rdy_sync  <= {r_rdy_sync[1:0], i_brust_ready};
    end
  end

  // Millisecond timer, live only in the delay states and cleared elsewhere
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_timing) begin
      r_ms_cnt <= '0;
      r_ms_num <= '0;
    end else if (w_ms_tick) begin
      r_ms_cnt <= '0;
      if (!w_delay_done) r_ms_num <= r_ms_num + MSN_W'(1);
    end else begin
      r_ms_cnt <= r_ms_cnt + MS_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_POR;
      r_cmd_idx     <= '0;
      r_byte_cnt    <= '0;
      o_send_en     <= 1'b0;
      o_brust_vaild <= 1'b0;
      o_send_data   <= '0;
      o_reg_addr    <= '0;
      o_fb_addr     <= '0;
      o_init_done   <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        S_POR: begin
          if (w_delay_done && !w_busy) begin
            r_cmd_idx <= '0;
            r_state   <= S_CMD_ISSUE;
          end
        end

        S_CMD_ISSUE: begin
          if (o_send_en && w_busy) begin
            o_send_en <= 1'b0;
            r_state   <= S_CMD_WAIT;
          end else begin
            o_send_en     <= 1'b1;
            o_reg_addr    <= CTRL_CMD;
            o_send_data   <= w_rom_cmd;
            o_brust_vaild <= 1'b0;
          end
        end

        S_CMD_WAIT: begin
          if (!w_busy) begin
            if (r_cmd_idx == IDX_W'(INIT_LEN - 1)) begin
              o_init_done <= 1'b1;
              r_byte_cnt  <= '0;
              r_state     <= S_DATA_LOAD;
            end else begin
              r_cmd_idx <= r_cmd_idx + IDX_W'(1);
              r_state   <= S_CMD_ISSUE;
            end
          end
        end

        // fb_addr already holds byte_cnt, so fb_data is valid on entry
        S_DATA_LOAD: begin
          o_send_data   <= i_fb_data;
          o_brust_vaild <= !w_last_byte;
          if (r_byte_cnt == '0) begin
            r_state <= S_DATA_ISSUE;
          end else begin
            o_fb_addr <= w_next_addr;
            r_state   <= S_DATA_STREAM;
          end
        end

        S_DATA_ISSUE: begin
          if (o_send_en && w_busy) begin
            o_send_en <= 1'b0;
            o_fb_addr <= w_next_addr;
            r_state   <= S_DATA_STREAM;
          end else begin
            o_send_en  <= 1'b1;
            o_reg_addr <= CTRL_DATA;
          end
        end

        S_DATA_STREAM: begin
          if (w_rdy_rise) begin
            if (!w_last_byte) begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
              r_state    <= S_DATA_LOAD;
            end else begin
              r_state <= S_DATA_END;
            end
          end
        end

        S_DATA_END: begin
          if (!w_busy) begin
            o_frame_done <= 1'b1;
            o_fb_addr    <= '0;
            r_state      <= S_GAP;
          end
        end

        S_GAP: begin
          if (w_delay_done) begin
            r_byte_cnt <= '0;
            r_state    <= S_DATA_LOAD;
          end
        end

        default: r_state <= S_POR;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_ctrl.sv
// Scoreboard bench for ssd1306_ctrl: a behavioural I2C master checks every
// byte it accepts against an expected queue filled by the stimulus process.
module tb_ssd1306_ctrl;

  localparam int unsigned CLK_FRE = 1;
  localparam int unsigned POR_MS  = 1;
  localparam int unsigned GAP_MS  = 1;
  localparam int unsigned MS_CYC  = CLK_FRE * 1000;

  typedef struct packed {
    logic [7:0] ctrl;
    logic [7:0] data;
    logic       vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_addr_ex;
  logic [15:0] slave_addr;
  logic        send_rw;
  logic [7:0]  reg_addr;
  logic        send_en;
  logic        send_busy;
  logic        brust_ready;
  logic        brust_vaild;
  logic [7:0]  send_data;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_data;
  logic        init_done;
  logic        frame_done;

  logic [7:0] fb_mem [1024];
  logic [7:0] init_tbl [31] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
    8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  exp_t exp_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hold_dly = 50;
  bit   abort = 1'b0;
  int   cmd_txn = 0;
  int   data_txn = 0;
  int   busy_falls = 0;
  int   data_idx = 0;
  int   fd_cnt = 0;
  logic fd_prev = 1'b0;

  ssd1306_ctrl #(
    .CLK_FRE      (CLK_FRE),
    .POR_MS       (POR_MS),
    .FRAME_GAP_MS (GAP_MS),
    .SLAVE_ADDR   (8'h78)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_slave_addr_ex (slave_addr_ex),
    .o_slave_addr    (slave_addr),
    .o_send_rw       (send_rw),
    .o_reg_addr      (reg_addr),
    .o_send_en       (send_en),
    .i_send_busy     (send_busy),
    .i_brust_ready   (brust_ready),
    .o_brust_vaild   (brust_vaild),
    .o_send_data     (send_data),
    .o_fb_addr       (fb_addr),
    .i_fb_data       (fb_data),
    .o_init_done     (init_done),
    .o_frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic sb_check(input logic [7:0] c, input logic [7:0] d, input logic v);
    exp_t e;
    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_ctrl", 32'(c), 32'(e.ctrl));
      chk("sb_data", 32'(d), 32'(e.data));
      chk("sb_vld", 32'(v), 32'(e.vld));
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 31; i++) exp_q.push_back('{8'h00, init_tbl[i], 1'b0});
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{8'h40, 8'(i), (i != 1023)});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_send_en"}, 32'(send_en), 0);
    chk({tag, "_vaild"}, 32'(brust_vaild), 0);
    chk({tag, "_send_data"}, 32'(send_data), 0);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 0);
    chk({tag, "_slave_addr"}, 32'(slave_addr), 32'h0078);
    chk({tag, "_addr_ex"}, 32'(slave_addr_ex), 0);
    chk({tag, "_send_rw"}, 32'(send_rw), 0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // frame_done must be a single-cycle pulse
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt++;
      chk("fd_pulse_width", 32'(fd_prev), 0);
    end
    fd_prev = frame_done;
  end

  // Behavioural I2C master and scoreboard monitor
  initial begin : master
    logic [7:0] ctrl;
    logic [7:0] d0;
    logic       vld;
    logic       prev_vld;
    send_busy   = 1'b0;
    brust_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (send_en === 1'b1 && !rst) begin
        d0 = send_data;
        if (hold_dly > 2) begin
          repeat (hold_dly) @(negedge clk);
          chk("hold_en", 32'(send_en), 1);
          chk("hold_data", 32'(send_data), 32'(d0));
          hold_dly = 2;
        end else begin
          repeat (hold_dly) @(negedge clk);
        end
        send_busy = 1'b1;
        ctrl = reg_addr;
        vld  = brust_vaild;
        sb_check(ctrl, send_data, vld);
        data_idx = 0;
        if (ctrl == 8'h40) data_txn++;
        else cmd_txn++;
        forever begin
          repeat (6) @(negedge clk);
          if (abort) break;
          prev_vld = vld;
          d0 = send_data;
          brust_ready = 1'b1;
          repeat (4) @(negedge clk);
          if (prev_vld) begin
            vld = brust_vaild;
            sb_check(ctrl, send_data, vld);
            data_idx++;
          end
          brust_ready = 1'b0;
          repeat (3) @(negedge clk);
          if (!prev_vld) begin
            if (ctrl == 8'h00) begin
              chk("cmd_wait_data", 32'(send_data), 32'(d0));
              chk("cmd_wait_fbaddr", 32'(fb_addr), 0);
            end
            break;
          end
        end
        if (abort) begin
          repeat (200) @(negedge clk);
          abort = 1'b0;
        end
        send_busy = 1'b0;
        busy_falls++;
        @(negedge clk);
        chk("en_after_busy", 32'(send_en), 0);
      end
    end
  end

  initial begin : stim
    int n;
    int t0;
    push_init();
    push_frame(1024);
    push_frame(1024);
    push_frame(501);

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    t0 = cyc;

    n = 0;
    while (send_en !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("por_en_seen", 32'(send_en), 1);
    chk("por_delay", 32'((cyc - t0) >= int'(MS_CYC)), 1);

    n = 0;
    while (init_done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    chk("init_done", 32'(init_done), 1);
    chk("init_cmd_txns", 32'(cmd_txn), 31);
    chk("init_busy_falls", 32'(busy_falls), 31);
    chk("init_data_txns", 32'(data_txn), 0);

    n = 0;
    while (fd_cnt < 1 && n < 40000) begin @(negedge clk); n++; end
    chk("frame1_done", 32'(fd_cnt), 1);
    chk("frame1_txns", 32'(data_txn), 1);
    chk("frame1_q_left", 32'(exp_q.size()), 1024 + 501);
    t0 = cyc;

    n = 0;
    while (send_en !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("gap_en_seen", 32'(send_en), 1);
    chk("gap_delay", 32'((cyc - t0) >= int'(MS_CYC)), 1);
    chk("gap_ctrl", 32'(reg_addr), 32'h40);

    n = 0;
    while (fd_cnt < 2 && n < 40000) begin @(negedge clk); n++; end
    chk("frame2_done", 32'(fd_cnt), 2);
    chk("frame2_txns", 32'(data_txn), 2);
    chk("frame2_q_left", 32'(exp_q.size()), 501);

    n = 0;
    while (!(data_txn == 3 && data_idx >= 500) && n < 20000) begin @(negedge clk); n++; end
    chk("frame3_byte500", 32'(data_idx), 500);
    chk("abort_q_left", 32'(exp_q.size()), 0);
    abort = 1'b1;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    t0 = cyc;
    push_init();

    n = 0;
    while (send_en !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("reinit_en_seen", 32'(send_en), 1);
    chk("reinit_delay", 32'((cyc - t0) >= int'(MS_CYC)), 1);
    chk("reinit_busy_low", 32'(send_busy), 0);
    chk("reinit_first_cmd", 32'(send_data), 32'hAE);

    n = 0;
    while (init_done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_cmd_txns", 32'(cmd_txn), 62);
    chk("reinit_q_left", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: test did not complete by cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
